sad_search_engine: RTL and testbench
====================================

# sad_search_engine

Parametrised block-matching engine for the SAD pipeline stages. It latches a BLK×BLK reference block, then accepts a raster-ordered stream of candidate blocks over a POS_X×POS_Y search window. For each candidate it computes the sum of absolute differences through a three-stage pipeline and tracks the minimum SAD with its (x,y) position. It generalises the fixed 4×4 SAD1/SAD2 stages into a configurable, handshaked, self-sequencing unit that sits between the memory stage's block fetch and writeback.

## Interface
Parameters:
- PIX_W, 8, unsigned pixel width in bits
- BLK, 4, block dimension; a block holds BLK*BLK pixels
- POS_X, 16, number of candidate x positions (≥1)
- POS_Y, 16, number of candidate y positions (≥1)

Derived (localparam):
- SAD_W = PIX_W + clog2(BLK*BLK)
- XW = max(1, clog2(POS_X))
- YW = max(1, clog2(POS_Y))

Ports:
- Clk, in, 1, sole clock, rising edge
- Reset, in, 1, asynchronous, active-high; forces IDLE and clears all registers
- Start, in, 1, begin a search; honoured only in IDLE or DONE
- RefBlock, in, BLK*BLK*PIX_W, reference block; sampled on an accepted Start
- CandValid, in, 1, CandBlock holds a valid candidate
- CandBlock, in, BLK*BLK*PIX_W, candidate block for the current (x,y)
- CandReady, out, 1, engine accepts a candidate this cycle
- SadValid, out, 1, one-cycle strobe: SadOut/SadX/SadY are valid
- SadOut, out, SAD_W, SAD of one candidate
- SadX, out, XW, x position of SadOut
- SadY, out, YW, y position of SadOut
- MinSAD, out, SAD_W, running or final minimum SAD
- MinX, out, XW, x position of MinSAD
- MinY, out, YW, y position of MinSAD
- Busy, out, 1, high in RUN and DRAIN
- Done, out, 1, high in DONE; results are final

Pixel packing: pixel i = row*BLK+col occupies bits [i*PIX_W +: PIX_W]. Pixels are unsigned.

## Operation
- States:
  - IDLE: Start → RUN. Latches RefBlock, clears x,y to 0, sets MinSAD to all-ones, sets MinX/MinY to 0.
  - RUN: CandReady=1. A candidate is accepted when CandValid&&CandReady.
    - On each accept, x increments. When x reaches POS_X-1 it wraps to 0 and y increments.
    - The accept at (POS_X-1, POS_Y-1) moves the engine to DRAIN, with CandReady=0 from the next cycle.
  - DRAIN: a 3-cycle countdown flushes the pipeline, then → DONE.
  - DONE: Done=1. MinSAD/MinX/MinY hold. Start → RUN, with the same actions as from IDLE.
- Start in RUN or DRAIN is ignored. CandValid outside RUN is ignored.
- Pipeline; position tags (x,y) and a valid bit travel with the data:
  - S1: per-pixel |ref−cand| registered, each PIX_W bits (no overflow).
  - S2: adder-tree sum of the S1 values registered at SAD_W; this sum drives SadOut. Full width, no saturation.
  - S3: if SadValid && SadOut < MinSAD, update MinSAD/MinX/MinY.
- Ties: strict less-than, so the earliest position in raster order wins.
- Counters advance only on accept. Gaps in CandValid insert pipeline bubbles, with valid bits low in those slots.

## Timing
- Reset values: CandReady, SadValid, SadOut, SadX, SadY, MinSAD, MinX, MinY, Busy and Done are all 0. State is IDLE and all pipeline valids are 0.
- Start accepted at edge s: Busy=1 and CandReady=1 after edge s. MinSAD is all-ones after s.
- Candidate accepted at edge t:
  - S1 registered at t+1.
  - SadValid=1 with its SadOut/SadX/SadY after edge t+2.
  - MinSAD update visible after edge t+3.
- Throughput: one candidate per cycle; a full search takes POS_X*POS_Y accepts.
- Last accept at edge k: CandReady=0 after k. Done=1 and Busy=0 after edge k+3, with the final minimum visible in the same cycle.
- Done stays high until Start is accepted. Done falls after the same edge at which Busy rises.
- Reset asserted mid-RUN or mid-DRAIN: all outputs clear immediately (asynchronously) and in-flight pipeline data is discarded. After deassertion, a new Start behaves normally.
- POS_X=POS_Y=1: one accept, then DRAIN, then DONE.

## Test plan
Configuration for all scenarios: PIX_W=8, BLK=2, POS_X=3, POS_Y=2, giving SAD_W=10.

1. Reset with no Start → all outputs 0 and CandReady=0. Holding CandValid=1 produces no SadValid.
2. RefBlock=4×0x10. Every candidate is 4×0x14 except (2,1), which is 4×0x10, all sent back-to-back → SadOut values 16,16,16,16,16,0. Final MinSAD=0, MinX=2, MinY=1. Done rises 3 cycles after the 6th accept.
3. RefBlock=4×0xFF, all candidates 4×0x00 → every SadOut=1020 (no truncation). MinSAD=1020 at (0,0).
4. Candidates produce SADs 5,5,9,9,9,9 → MinSAD=5 at (0,0) (tie keeps the earlier position).
5. Same stream as scenario 2 with CandValid high only on alternate cycles → identical SadOut sequence and positions, with SadValid gaps matching the input gaps. Same final result.
6. Reset asserted after the 3rd accept → immediate all-zero outputs. A new Start then a full stream → correct result; Start pulsed during RUN has no effect.

Source files
------------

// File: rtl/sad_search_engine.sv
// ---------------------------------------------------------------------------
// sad_search_engine
//
// Block-matching engine. A BLK x BLK reference block is latched on Start, then
// POS_X*POS_Y candidate blocks arrive in raster order over a ready/valid
// handshake. Each candidate's sum of absolute differences is computed through
// an input register plus a three-stage pipeline (|diff|, adder tree, minimum
// tracker), and the smallest SAD is kept together with its (x,y) position.
//
// Ports
//   Clk        in   sole clock, rising edge
//   Reset      in   asynchronous, active-high; returns to IDLE, clears state
//   Start      in   begin a search (honoured in IDLE or DONE only)
//   RefBlock   in   reference block, sampled on an accepted Start
//   CandValid  in   CandBlock carries a candidate
//   CandBlock  in   candidate block for the current (x,y)
//   CandReady  out  engine takes a candidate this cycle
//   SadValid   out  one-cycle strobe qualifying SadOut/SadX/SadY
//   SadOut     out  SAD of one candidate
//   SadX/SadY  out  position of SadOut
//   MinSAD     out  running / final minimum SAD
//   MinX/MinY  out  position of MinSAD
//   Busy       out  high in RUN and DRAIN
//   Done       out  high in DONE; minimum is final
//
// Pixel i = row*BLK+col sits at bits [i*PIX_W +: PIX_W], unsigned.
// ---------------------------------------------------------------------------
module sad_search_engine #(
  parameter  int unsigned PIX_W = 8,
  parameter  int unsigned BLK   = 4,
  parameter  int unsigned POS_X = 16,
  parameter  int unsigned POS_Y = 16,
  localparam int unsigned NPIX  = BLK * BLK,
  localparam int unsigned BLK_W = NPIX * PIX_W,
  localparam int unsigned SAD_W = PIX_W + $clog2(NPIX),
  localparam int unsigned XW    = (POS_X > 1) ? $clog2(POS_X) : 1,
  localparam int unsigned YW    = (POS_Y > 1) ? $clog2(POS_Y) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [BLK_W-1:0] RefBlock,
  input  logic             CandValid,
  input  logic [BLK_W-1:0] CandBlock,
  output logic             CandReady,
  output logic             SadValid,
  output logic [SAD_W-1:0] SadOut,
  output logic [XW-1:0]    SadX,
  output logic [YW-1:0]    SadY,
  output logic [SAD_W-1:0] MinSAD,
  output logic [XW-1:0]    MinX,
  output logic [YW-1:0]    MinY,
  output logic             Busy,
  output logic             Done
);

  localparam logic [XW-1:0] X_LAST = XW'(POS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(POS_Y - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // -------------------------------------------------------------------------
  // Control FSM: sequencing, position counters and registered status outputs
  // -------------------------------------------------------------------------
  state_e             state_q;
  logic [1:0]         drain_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [BLK_W-1:0]   ref_q;
  logic               cand_ready_q;
  logic               busy_q;
  logic               done_q;

  logic accept;
  logic start_acc;

  // cand_ready_q is high exactly in RUN, so it doubles as the RUN qualifier.
  assign accept    = CandValid && cand_ready_q;
  assign start_acc = Start && ((state_q == IDLE) || (state_q == DONE));

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values of each other, independent of block ordering.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      ref_q        <= '0;
      cand_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q      <= RUN;
            ref_q        <= RefBlock;
            x_q          <= '0;
            y_q          <= '0;
            cand_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q          <= '0;
                state_q      <= DRAIN;
                cand_ready_q <= 1'b0;
                // Three edges flush the last candidate through S1, S2, S3.
                drain_q      <= 2'd2;
              end else begin
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 2'd0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath pipeline; valid bit and (x,y) tag travel alongside the data
  // -------------------------------------------------------------------------
  logic                       in_valid_q;
  logic [BLK_W-1:0]           in_cand_q;
  logic [XW-1:0]              in_x_q;
  logic [YW-1:0]              in_y_q;

  logic                       s1_valid_q;
  logic [NPIX-1:0][PIX_W-1:0] s1_diff_q;
  logic [XW-1:0]              s1_x_q;
  logic [YW-1:0]              s1_y_q;

  logic                       sad_valid_q;
  logic [SAD_W-1:0]           sad_q;
  logic [XW-1:0]              sad_x_q;
  logic [YW-1:0]              sad_y_q;

  logic [SAD_W-1:0]           min_sad_q;
  logic [XW-1:0]              min_x_q;
  logic [YW-1:0]              min_y_q;

  logic [NPIX-1:0][PIX_W-1:0] diff_d;
  logic [PIX_W-1:0]           ref_px;
  logic [PIX_W-1:0]           cand_px;
  logic [SAD_W-1:0]           sum_d;

  // NOTE: each always_comb target gets a default before any conditional or
  // looped assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    diff_d  = '0;
    ref_px  = '0;
    cand_px = '0;
    for (int i = 0; i < NPIX; i++) begin
      ref_px    = ref_q[i*PIX_W +: PIX_W];
      cand_px   = in_cand_q[i*PIX_W +: PIX_W];
      // Subtract the smaller from the larger: the result always fits PIX_W.
      diff_d[i] = (ref_px >= cand_px) ? (ref_px - cand_px) : (cand_px - ref_px);
    end
  end

  // Summed at full SAD_W width; NPIX*(2^PIX_W-1) cannot overflow it.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NPIX; i++) begin
      sum_d = sum_d + SAD_W'(s1_diff_q[i]);
    end
  end

  // NOTE: the pipeline data registers are reset along with their valid bits
  // so SadOut/SadX/SadY read as zero after Reset, not merely "don't care".
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_valid_q  <= 1'b0;
      in_cand_q   <= '0;
      in_x_q      <= '0;
      in_y_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      sad_valid_q <= 1'b0;
      sad_q       <= '0;
      sad_x_q     <= '0;
      sad_y_q     <= '0;
    end else begin
      // Input capture: a bubble just drops the valid bit.
      in_valid_q <= accept;
      if (accept) begin
        in_cand_q <= CandBlock;
        in_x_q    <= x_q;
        in_y_q    <= y_q;
      end
      // S1: per-pixel absolute difference.
      s1_valid_q  <= in_valid_q;
      s1_diff_q   <= diff_d;
      s1_x_q      <= in_x_q;
      s1_y_q      <= in_y_q;
      // S2: adder tree.
      sad_valid_q <= s1_valid_q;
      sad_q       <= sum_d;
      sad_x_q     <= s1_x_q;
      sad_y_q     <= s1_y_q;
    end
  end

  // S3: minimum tracker. Strict less-than keeps the earliest raster position
  // on ties. The pipeline is empty whenever Start can be accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      min_sad_q <= '0;
      min_x_q   <= '0;
      min_y_q   <= '0;
    end else if (start_acc) begin
      min_sad_q <= '1;
      min_x_q   <= '0;
      min_y_q   <= '0;
    end else if (sad_valid_q && (sad_q < min_sad_q)) begin
      min_sad_q <= sad_q;
      min_x_q   <= sad_x_q;
      min_y_q   <= sad_y_q;
    end
  end

  assign CandReady = cand_ready_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign SadValid  = sad_valid_q;
  assign SadOut    = sad_q;
  assign SadX      = sad_x_q;
  assign SadY      = sad_y_q;
  assign MinSAD    = min_sad_q;
  assign MinX      = min_x_q;
  assign MinY      = min_y_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// ---------------------------------------------------------------------------
// tb_sad_search_engine
//
// Directed and randomized searches on a 2x2-block, 3x2-position engine. The
// expected SAD of each candidate comes from plain per-pixel arithmetic, and
// the expected SadValid slot, running minimum and Done timing come from the
// accept cycle of each candidate (SAD two edges later, minimum three).
// ---------------------------------------------------------------------------
module tb_sad_search_engine;

  localparam int PIX_W = 8;
  localparam int BLK   = 2;
  localparam int POS_X = 3;
  localparam int POS_Y = 2;
  localparam int N     = POS_X * POS_Y;
  localparam int BW    = BLK * BLK * PIX_W;
  localparam int SAD_W = 10;
  localparam int XW    = 2;
  localparam int YW    = 1;
  localparam int ALL1  = (1 << SAD_W) - 1;

  typedef logic [BW-1:0] blk_t;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  blk_t             RefBlock;
  logic             CandValid;
  blk_t             CandBlock;
  logic             CandReady;
  logic             SadValid;
  logic [SAD_W-1:0] SadOut;
  logic [XW-1:0]    SadX;
  logic [YW-1:0]    SadY;
  logic [SAD_W-1:0] MinSAD;
  logic [XW-1:0]    MinX;
  logic [YW-1:0]    MinY;
  logic             Busy;
  logic             Done;

  sad_search_engine #(
    .PIX_W(PIX_W), .BLK(BLK), .POS_X(POS_X), .POS_Y(POS_Y)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RefBlock(RefBlock),
    .CandValid(CandValid), .CandBlock(CandBlock), .CandReady(CandReady),
    .SadValid(SadValid), .SadOut(SadOut), .SadX(SadX), .SadY(SadY),
    .MinSAD(MinSAD), .MinX(MinX), .MinY(MinY), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  blk_t cands[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic blk_t fill(input logic [7:0] v);
    return {4{v}};
  endfunction

  function automatic int ref_sad(input blk_t a, input blk_t b);
    int s = 0;
    for (int i = 0; i < BLK * BLK; i++) begin
      int pa = int'(a[i*PIX_W +: PIX_W]);
      int pb = int'(b[i*PIX_W +: PIX_W]);
      s += (pa > pb) ? (pa - pb) : (pb - pa);
    end
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".CandReady"}, 32'(CandReady), 0);
    check({tag, ".SadValid"},  32'(SadValid),  0);
    check({tag, ".SadOut"},    32'(SadOut),    0);
    check({tag, ".SadX"},      32'(SadX),      0);
    check({tag, ".SadY"},      32'(SadY),      0);
    check({tag, ".MinSAD"},    32'(MinSAD),    0);
    check({tag, ".MinX"},      32'(MinX),      0);
    check({tag, ".MinY"},      32'(MinY),      0);
    check({tag, ".Busy"},      32'(Busy),      0);
    check({tag, ".Done"},      32'(Done),      0);
  endtask

  // One full search over cands[]. gaps: CandValid only on odd cycles.
  // poke_start: pulse Start mid-RUN, which must change nothing.
  task automatic run_search(input string tag, input blk_t rblk,
                            input bit gaps, input bit poke_start,
                            input int exp_min, input int exp_mx, input int exp_my);
    int acc[64];
    int exp_sad[N];
    int k, best, bx, by, last, idx, midx;
    for (int i = 0; i < 64; i++) acc[i] = -1;
    for (int i = 0; i < N; i++) exp_sad[i] = ref_sad(rblk, cands[i]);

    RefBlock = rblk;
    Start    = 1'b1;
    step();
    Start    = 1'b0;
    RefBlock = blk_t'($urandom);   // must have been latched already
    check({tag, ".start.Busy"},      32'(Busy),      1);
    check({tag, ".start.CandReady"}, 32'(CandReady), 1);
    check({tag, ".start.Done"},      32'(Done),      0);
    check({tag, ".start.MinSAD"},    32'(MinSAD),    ALL1);

    k = 0; best = ALL1; bx = 0; by = 0; last = -1;
    for (int c = 1; c < 64; c++) begin
      CandValid = (k < N) && (!gaps || (c % 2 == 1));
      CandBlock = CandValid ? cands[k] : blk_t'($urandom);
      Start     = poke_start && (c == 3);
      if (CandValid) begin
        acc[c] = k;
        k++;
        if (k == N) last = c;
      end
      step();
      CandValid = 1'b0;
      Start     = 1'b0;

      idx = (c >= 3) ? acc[c-2] : -1;
      check({tag, ".SadValid"}, 32'(SadValid), (idx >= 0) ? 1 : 0);
      if (idx >= 0) begin
        check({tag, ".SadOut"}, 32'(SadOut), exp_sad[idx]);
        check({tag, ".SadX"},   32'(SadX),   idx % POS_X);
        check({tag, ".SadY"},   32'(SadY),   idx / POS_X);
      end

      midx = (c >= 4) ? acc[c-3] : -1;
      if (midx >= 0 && exp_sad[midx] < best) begin
        best = exp_sad[midx];
        bx   = midx % POS_X;
        by   = midx / POS_X;
      end
      check({tag, ".MinSAD"},    32'(MinSAD),    best);
      check({tag, ".MinX"},      32'(MinX),      bx);
      check({tag, ".MinY"},      32'(MinY),      by);
      check({tag, ".CandReady"}, 32'(CandReady), (last < 0) ? 1 : 0);
      check({tag, ".Done"},      32'(Done),      (last >= 0 && c >= last + 3) ? 1 : 0);
      check({tag, ".Busy"},      32'(Busy),      (last >= 0 && c >= last + 3) ? 0 : 1);
      if (last >= 0 && c == last + 4) break;
    end
    check({tag, ".final.accepts"}, 32'(k), N);
    check({tag, ".final.MinSAD"},  32'(MinSAD), exp_min);
    check({tag, ".final.MinX"},    32'(MinX),   exp_mx);
    check({tag, ".final.MinY"},    32'(MinY),   exp_my);
    check({tag, ".final.Done"},    32'(Done),   1);
  endtask

  // Independent whole-search answer: earliest strict minimum in raster order.
  task automatic model_min(input blk_t rblk, output int m, output int mx, output int my);
    int mi = 0;
    m = ref_sad(rblk, cands[0]);
    for (int i = 1; i < N; i++)
      if (ref_sad(rblk, cands[i]) < m) begin
        m  = ref_sad(rblk, cands[i]);
        mi = i;
      end
    mx = mi % POS_X;
    my = mi / POS_X;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    blk_t r;
    int   m, mx, my;
    Reset = 1'b1; Start = 1'b0; CandValid = 1'b0;
    RefBlock = '0; CandBlock = '0;

    // 1: reset, no Start; CandValid is ignored outside RUN
    step(); step();
    Reset = 1'b0;
    step();
    check_all_zero("reset");
    for (int i = 0; i < 4; i++) begin
      CandValid = 1'b1;
      CandBlock = blk_t'($urandom);
      step();
      check("idle.SadValid",  32'(SadValid),  0);
      check("idle.CandReady", 32'(CandReady), 0);
      check("idle.Busy",      32'(Busy),      0);
    end
    CandValid = 1'b0;
    step(); step();
    check("idle.SadValid.late", 32'(SadValid), 0);

    // 2: one exact match at (2,1), back-to-back
    for (int i = 0; i < N; i++) cands[i] = fill(8'h14);
    cands[5] = fill(8'h10);
    run_search("s2", fill(8'h10), 1'b0, 1'b0, 0, 2, 1);

    // 3: full-range differences, no truncation
    for (int i = 0; i < N; i++) cands[i] = fill(8'h00);
    run_search("s3", fill(8'hFF), 1'b0, 1'b0, 1020, 0, 0);

    // 4: tie at the minimum keeps the earliest position
    cands[0] = {24'h0, 8'd5};
    cands[1] = {8'd5, 24'h0};
    for (int i = 2; i < N; i++) cands[i] = {8'd3, 8'd3, 8'd3, 8'd0};
    run_search("s4", fill(8'h00), 1'b0, 1'b0, 5, 0, 0);

    // 5: scenario 2 stream with bubbles between candidates
    for (int i = 0; i < N; i++) cands[i] = fill(8'h14);
    cands[5] = fill(8'h10);
    run_search("s5", fill(8'h10), 1'b1, 1'b0, 0, 2, 1);

    // randomized searches, with and without bubbles
    for (int t = 0; t < 4; t++) begin
      r = blk_t'($urandom);
      for (int i = 0; i < N; i++) cands[i] = blk_t'($urandom);
      model_min(r, m, mx, my);
      run_search("rand", r, t[0], 1'b0, m, mx, my);
    end

    // 6: asynchronous reset after the 3rd accept, then a clean search
    RefBlock = blk_t'($urandom);
    Start    = 1'b1;
    step();
    Start    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      CandValid = 1'b1;
      CandBlock = blk_t'($urandom);
      step();
    end
    CandValid = 1'b0;
    check("s6.pre.Busy",     32'(Busy),     1);
    check("s6.pre.SadValid", 32'(SadValid), 1);
    #2 Reset = 1'b1;
    #1 check_all_zero("s6.async");
    @(negedge Clk);
    Reset = 1'b0;
    step(); step();
    check_all_zero("s6.after");
    r = blk_t'($urandom);
    for (int i = 0; i < N; i++) cands[i] = blk_t'($urandom);
    model_min(r, m, mx, my);
    run_search("s6", r, 1'b0, 1'b1, m, mx, my);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
